axi32_regbank_cell: RTL and testbench
=====================================

// Module: axi32_regbank_cell
// PURPOSE
//  Parametrised AXI4-Lite slave register bank, the successor to the fixed 3-register cell.
//  Exposes a read-only ID word, ctrl_num R/W control words, stat_num RO status words and a
//  sticky W1C interrupt block with enable mask. Sits between the PS/interconnect AXI-Lite
//  master and a CBB's control/status fabric; one instance per CBB.
// PARAMETERS
//  datawidth  32            data bus width; only 32 is supported (wstrb = 4 bits)
//  addrwidth  8             byte address width; must be >= 8
//  ctrl_num   4             number of control words, 1..15
//  stat_num   4             number of status words, 1..16
//  cbbid      32'h54460001  value returned at offset 0x00
// PORTS
//  s_axi_clk_in       in   1                   single clock
//  s_axi_reset_n_in   in   1                   reset, asynchronous assert, active low
//  s_axi_awaddr_in    in   addrwidth           write address
//  s_axi_awvalid_in   in   1                   write address valid
//  s_axi_awready_out  out  1                   write address ready
//  s_axi_wdata_in     in   datawidth           write data
//  s_axi_wstrb_in     in   datawidth/8         byte strobes
//  s_axi_wvalid_in    in   1                   write data valid
//  s_axi_wready_out   out  1                   write data ready
//  s_axi_bresp_out    out  2                   write response: 00 OKAY, 10 SLVERR
//  s_axi_bvalid_out   out  1                   write response valid
//  s_axi_bready_in    in   1                   write response ready
//  s_axi_araddr_in    in   addrwidth           read address
//  s_axi_arvalid_in   in   1                   read address valid
//  s_axi_arready_out  out  1                   read address ready
//  s_axi_rdata_out    out  datawidth           read data
//  s_axi_rresp_out    out  2                   read response: 00 OKAY, 10 SLVERR
//  s_axi_rvalid_out   out  1                   read data valid
//  s_axi_rready_in    in   1                   read data ready
//  control_out        out  ctrl_num*datawidth  control word i at [32i+31:32i]
//  status_in          in   stat_num*datawidth  status word j at [32j+31:32j]; synchronous to clk
//  irq_src_in         in   datawidth           interrupt sources, rising-edge detected
//  irq_out            out  1                   registered |(IRQ_PEND & IRQ_EN)
// BEHAVIOUR
//  Map (addr[1:0] ignored): 0x00 ID RO; 0x04+4i CTRL[i] RW; 0x40+4j STAT[j] RO (live sample);
//   0x80 IRQ_PEND RO/W1C; 0x84 IRQ_EN RW. Any other offset is unmapped.
//  Reset: every output 0; CTRL, IRQ_EN, IRQ_PEND and the edge-detect history are 0.
//  Write FSM: IDLE -> GOT_A (AW first) | GOT_D (W first) | EXEC (both in the same cycle);
//   GOT_A/GOT_D -> EXEC when the missing beat arrives; EXEC (1 cycle: apply write) -> RESP; RESP -> IDLE on bvalid&bready.
//   awready = 1 in IDLE and GOT_D; wready = 1 in IDLE and GOT_A; both 0 in EXEC and RESP.
//   Addr/data/strb are latched at handshake; bvalid rises 1 cycle after EXEC and holds with bresp stable until bready.
//  Write effects: CTRL/IRQ_EN are updated per byte lane by wstrb. IRQ_PEND: for each set bit of masked wdata, clear the bit.
//   Writes to ID, STAT or unmapped offsets change nothing and respond SLVERR; all others respond OKAY.
//  Read FSM: IDLE (arready=1) -> RDATA on arvalid&arready; in RDATA arready=0 and rvalid=1, with rdata/rresp
//   registered at the AR handshake (1-cycle latency) and held until rready; -> IDLE on rvalid&rready.
//   Unmapped read: rdata = 0, rresp = SLVERR. Read and write channels operate fully concurrently.
//  IRQ: edge = irq_src_in & ~irq_src_q (history register). PEND <= (PEND & ~w1c) | edge; a set takes priority over a
//   clear of the same bit in the same cycle. irq_out is registered and lags PEND/EN by 1 cycle.
//  Reset asserted mid-transaction aborts it: valids drop asynchronously and no response is issued afterwards.
// TESTING
//  1. Reset, read 0x00 -> rvalid 1 cycle after AR handshake, rdata=cbbid, OKAY; control_out=0, irq_out=0.
//  2. W before AW by 3 cycles, 0x08 data 0xA5A5_5A5A strb 4'b0101 -> CTRL[1]=0x00A5_005A, OKAY; bready held low 5 cycles -> bvalid/bresp stable.
//  3. Write 0x00 and 0xF0 -> SLVERR, no state change; read 0xF0 -> rdata 0, SLVERR; read 0x44 with status word1=0x1234 -> 0x1234.
//  4. IRQ_EN=0x1; pulse irq_src_in[0] -> PEND[0]=1, irq_out=1 a cycle later; W1C 0x1 -> PEND 0, irq_out low.
//  5. W1C of PEND[0] in the same cycle as a new irq_src_in[0] edge -> PEND[0] remains 1.
//  6. Overlapping read of 0x04 and write of 0x04 -> both complete; reset asserted in RESP -> bvalid 0 at once, FSM IDLE.

Source files
------------

// File: rtl/axi32_regbank_cell.sv
// AXI4-Lite slave register bank: read-only ID word, R/W control words, live status words,
// and a sticky W1C interrupt block with an enable mask.
module axi32_regbank_cell #(
  parameter int          datawidth = 32,
  parameter int          addrwidth = 8,
  parameter int          ctrl_num  = 4,
  parameter int          stat_num  = 4,
  parameter logic [31:0] cbbid     = 32'h5446_0001
) (
  input  logic                          s_axi_clk_in,
  input  logic                          s_axi_reset_n_in,
  input  logic [addrwidth-1:0]          s_axi_awaddr_in,
  input  logic                          s_axi_awvalid_in,
  output logic                          s_axi_awready_out,
  input  logic [datawidth-1:0]          s_axi_wdata_in,
  input  logic [datawidth/8-1:0]        s_axi_wstrb_in,
  input  logic                          s_axi_wvalid_in,
  output logic                          s_axi_wready_out,
  output logic [1:0]                    s_axi_bresp_out,
  output logic                          s_axi_bvalid_out,
  input  logic                          s_axi_bready_in,
  input  logic [addrwidth-1:0]          s_axi_araddr_in,
  input  logic                          s_axi_arvalid_in,
  output logic                          s_axi_arready_out,
  output logic [datawidth-1:0]          s_axi_rdata_out,
  output logic [1:0]                    s_axi_rresp_out,
  output logic                          s_axi_rvalid_out,
  input  logic                          s_axi_rready_in,
  output logic [ctrl_num*datawidth-1:0] control_out,
  input  logic [stat_num*datawidth-1:0] status_in,
  input  logic [datawidth-1:0]          irq_src_in,
  output logic                          irq_out
);

  localparam int aw_word = addrwidth - 2;
  localparam int strb_w  = datawidth / 8;

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  localparam logic [aw_word-1:0] idx_id   = '0;
  localparam logic [aw_word-1:0] idx_pend = aw_word'(32);
  localparam logic [aw_word-1:0] idx_en   = aw_word'(33);

  typedef enum logic [2:0] {W_IDLE, W_GOT_A, W_GOT_D, W_EXEC, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t ws, ws_nxt;
  rstate_t rs, rs_nxt;

  logic                               live_q;
  logic [aw_word-1:0]                 awaddr_q;
  logic [datawidth-1:0]               wdata_q;
  logic [strb_w-1:0]                  wstrb_q;
  logic [1:0]                         bresp_q;
  logic [datawidth-1:0]               rdata_q;
  logic [1:0]                         rresp_q;

  logic [ctrl_num-1:0][datawidth-1:0] ctrl_q;
  logic [datawidth-1:0]               irq_en_q;
  logic [datawidth-1:0]               irq_pend_q;
  logic [datawidth-1:0]               irq_src_q;
  logic                               irq_q;

  logic                               aw_hs, w_hs, ar_hs, wr_exec;
  logic [ctrl_num-1:0]                wr_ctrl_hit;
  logic                               wr_en_hit, wr_pend_hit, wr_err;
  logic [datawidth-1:0]               wmask, w1c, irq_edge;
  logic [aw_word-1:0]                 ridx;
  logic [datawidth-1:0]               rd_data;
  logic                               rd_err;

  // Address bits [1:0] never take part in decoding.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr_in[1:0], s_axi_araddr_in[1:0]};

  // Holds the ready outputs low while reset is asserted and for the first cycle after release.
  always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
    if (!s_axi_reset_n_in) live_q <= 1'b0;
    else                   live_q <= 1'b1;
  end

  assign s_axi_awready_out = live_q & ((ws == W_IDLE) | (ws == W_GOT_D));
  assign s_axi_wready_out  = live_q & ((ws == W_IDLE) | (ws == W_GOT_A));
  assign s_axi_bvalid_out  = (ws == W_RESP);
  assign s_axi_bresp_out   = bresp_q;
  assign s_axi_arready_out = live_q & (rs == R_IDLE);
  assign s_axi_rvalid_out  = (rs == R_DATA);
  assign s_axi_rdata_out   = rdata_q;
  assign s_axi_rresp_out   = rresp_q;
  assign control_out       = ctrl_q;
  assign irq_out           = irq_q;

  assign aw_hs   = s_axi_awvalid_in & s_axi_awready_out;
  assign w_hs    = s_axi_wvalid_in  & s_axi_wready_out;
  assign ar_hs   = s_axi_arvalid_in & s_axi_arready_out;
  assign wr_exec = (ws == W_EXEC);

  // ---------------- write channel ----------------
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    ws_nxt = ws;
    case (ws)
      W_IDLE:  if (aw_hs && w_hs) ws_nxt = W_EXEC;
               else if (aw_hs)    ws_nxt = W_GOT_A;
               else if (w_hs)     ws_nxt = W_GOT_D;
      W_GOT_A: if (w_hs)  ws_nxt = W_EXEC;
      W_GOT_D: if (aw_hs) ws_nxt = W_EXEC;
      W_EXEC:  ws_nxt = W_RESP;
      W_RESP:  if (s_axi_bready_in) ws_nxt = W_IDLE;
      default: ws_nxt = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
    if (!s_axi_reset_n_in) begin
      ws       <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= resp_okay;
    end else begin
      ws <= ws_nxt;
      if (aw_hs) awaddr_q <= s_axi_awaddr_in[addrwidth-1:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata_in;
        wstrb_q <= s_axi_wstrb_in;
      end
      if (wr_exec) bresp_q <= wr_err ? resp_slverr : resp_okay;
    end
  end

  always_comb begin
    wr_ctrl_hit = '0;
    wr_en_hit   = (awaddr_q == idx_en);
    wr_pend_hit = (awaddr_q == idx_pend);
    for (int i = 0; i < ctrl_num; i++)
      if (awaddr_q == aw_word'(i + 1)) wr_ctrl_hit[i] = 1'b1;
    wr_err = ~(|wr_ctrl_hit | wr_en_hit | wr_pend_hit);
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < strb_w; b++) wmask[8*b +: 8] = {8{wstrb_q[b]}};
  end

  assign w1c      = (wr_exec && wr_pend_hit) ? (wdata_q & wmask) : '0;
  assign irq_edge = irq_src_in & ~irq_src_q;

  // ---------------- register bank and interrupt block ----------------
  // NOTE: the bank is a handful of flops, not a RAM, so every word is reset to a known value.
  always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
    if (!s_axi_reset_n_in) begin
      ctrl_q     <= '0;
      irq_en_q   <= '0;
      irq_pend_q <= '0;
      irq_src_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < ctrl_num; i++)
        if (wr_exec && wr_ctrl_hit[i]) ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (wdata_q & wmask);
      if (wr_exec && wr_en_hit) irq_en_q <= (irq_en_q & ~wmask) | (wdata_q & wmask);
      // A new edge wins over a W1C of the same bit in the same cycle.
      irq_pend_q <= (irq_pend_q & ~w1c) | irq_edge;
      irq_src_q  <= irq_src_in;
      irq_q      <= |(irq_pend_q & irq_en_q);
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    ridx    = s_axi_araddr_in[addrwidth-1:2];
    if (ridx == idx_id) begin
      rd_data = cbbid;
      rd_err  = 1'b0;
    end
    for (int i = 0; i < ctrl_num; i++)
      if (ridx == aw_word'(i + 1)) begin
        rd_data = ctrl_q[i];
        rd_err  = 1'b0;
      end
    for (int j = 0; j < stat_num; j++)
      if (ridx == aw_word'(16 + j)) begin
        rd_data = status_in[datawidth*j +: datawidth];
        rd_err  = 1'b0;
      end
    if (ridx == idx_pend) begin
      rd_data = irq_pend_q;
      rd_err  = 1'b0;
    end
    if (ridx == idx_en) begin
      rd_data = irq_en_q;
      rd_err  = 1'b0;
    end
  end

  always_comb begin
    rs_nxt = rs;
    case (rs)
      R_IDLE:  if (ar_hs) rs_nxt = R_DATA;
      R_DATA:  if (s_axi_rready_in) rs_nxt = R_IDLE;
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
    if (!s_axi_reset_n_in) begin
      rs      <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= resp_okay;
    end else begin
      rs <= rs_nxt;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? resp_slverr : resp_okay;
      end
    end
  end

endmodule

// File: tb/tb_axi32_regbank_cell.sv
// Directed bench for axi32_regbank_cell: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares them whenever a handshake is presented.
module tb_axi32_regbank_cell;

  localparam logic [31:0] cbbid  = 32'h5446_0001;
  localparam logic [1:0]  okay   = 2'b00;
  localparam logic [1:0]  slverr = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata, irq_src;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] control, status;
  logic         irq;

  always #5 clk = ~clk;

  axi32_regbank_cell dut (
    .s_axi_clk_in      (clk),
    .s_axi_reset_n_in  (rst_n),
    .s_axi_awaddr_in   (awaddr),
    .s_axi_awvalid_in  (awvalid),
    .s_axi_awready_out (awready),
    .s_axi_wdata_in    (wdata),
    .s_axi_wstrb_in    (wstrb),
    .s_axi_wvalid_in   (wvalid),
    .s_axi_wready_out  (wready),
    .s_axi_bresp_out   (bresp),
    .s_axi_bvalid_out  (bvalid),
    .s_axi_bready_in   (bready),
    .s_axi_araddr_in   (araddr),
    .s_axi_arvalid_in  (arvalid),
    .s_axi_arready_out (arready),
    .s_axi_rdata_out   (rdata),
    .s_axi_rresp_out   (rresp),
    .s_axi_rvalid_out  (rvalid),
    .s_axi_rready_in   (rready),
    .control_out       (control),
    .status_in         (status),
    .irq_src_in        (irq_src),
    .irq_out           (irq)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t       exp_r[$];
  logic [1:0]  exp_b[$];
  rexp_t       cur_r;
  logic [1:0]  cur_b;
  int checks = 0, failures = 0, r_seen = 0, b_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: compares every completed R and B handshake against the queued expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) timeout("unexpected_r");
      else begin
        cur_r = exp_r.pop_front();
        check("rdata", rdata, cur_r.data);
        check("rresp", rresp, cur_r.resp);
      end
      r_seen++;
    end
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) timeout("unexpected_b");
      else begin
        cur_b = exp_b.pop_front();
        check("bresp", bresp, cur_b);
      end
      b_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_seen(input bit is_b, input int target, input string name);
    for (int n = 0; n < 64 && ((is_b ? b_seen : r_seen) < target); n++) tick();
    if ((is_b ? b_seen : r_seen) < target) timeout(name);
  endtask

  task automatic drive_aw(input logic [7:0] a);
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 64 && !awready; n++) tick();
    if (!awready) timeout("aw_ready");
    else tick();
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 64 && !wready; n++) tick();
    if (!wready) timeout("w_ready");
    else tick();
    wvalid = 1'b0;
  endtask

  // Drives AW and W together and returns right after the joint handshake edge.
  task automatic drive_aw_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int n = 0; n < 64 && !(awready && wready); n++) tick();
    if (!(awready && wready)) timeout("aw_w_ready");
    else tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  // lead > 0: W goes first by lead cycles; lead < 0: AW goes first; 0: same cycle.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input int lead);
    int tgt = b_seen + 1;
    exp_b.push_back(resp);
    if (lead == 0) drive_aw_w(a, d, s);
    else if (lead > 0) begin
      drive_w(d, s);
      repeat (lead - 1) tick();
      drive_aw(a);
    end else begin
      drive_aw(a);
      repeat (-lead - 1) tick();
      drive_w(d, s);
    end
    wait_seen(1'b1, tgt, "b_done");
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp);
    int tgt = r_seen + 1;
    exp_r.push_back('{data: d, resp: resp});
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 64 && !arready; n++) tick();
    if (!arready) timeout("ar_ready");
    else tick();
    arvalid = 1'b0;
    wait_seen(1'b0, tgt, "r_done");
  endtask

  initial begin
    int tgt;
    rst_n = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1'b1; rready = 1'b1; wdata = '0; wstrb = '0; irq_src = '0;
    status = {32'hCAFE_0003, 32'hCAFE_0002, 32'h0000_1234, 32'hCAFE_0000};
    #2 rst_n = 1'b0;
    #1;
    // 1. reset state and ID read latency
    check("rst_awready", awready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_control", control, 0);
    check("rst_irq", irq, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    tgt = r_seen + 1;
    exp_r.push_back('{data: cbbid, resp: okay});
    araddr  = 8'h00;
    arvalid = 1'b1;
    for (int n = 0; n < 64 && !arready; n++) tick();
    check("rvalid_before_ar", rvalid, 0);
    tick();
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1);
    wait_seen(1'b0, tgt, "id_read");

    // 2. W three cycles ahead of AW, partial strobes, delayed bready
    bready = 1'b0;
    exp_b.push_back(okay);
    tgt = b_seen + 1;
    drive_w(32'hA5A5_5A5A, 4'b0101);
    repeat (2) tick();
    drive_aw(8'h08);
    for (int n = 0; n < 64 && !bvalid; n++) tick();
    if (!bvalid) timeout("bvalid_rise");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, okay);
    end
    tick();
    bready = 1'b1;
    wait_seen(1'b1, tgt, "b_delayed");
    check("ctrl1_strb", control, {32'h0, 32'h0, 32'h00A5_005A, 32'h0});

    // 3. error responses, unmapped reads, live status
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, slverr, 0);
    axi_write(8'hF0, 32'hFFFF_FFFF, 4'hF, slverr, 0);
    axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, slverr, 1);
    check("ctrl_after_err", control, {32'h0, 32'h0, 32'h00A5_005A, 32'h0});
    axi_read(8'hF0, 32'h0, slverr);
    axi_read(8'h3C, 32'h0, slverr);
    axi_read(8'h44, 32'h0000_1234, okay);
    axi_read(8'h4F, 32'hCAFE_0003, okay);
    axi_write(8'h10, 32'h1122_3344, 4'b1100, okay, -2);
    axi_read(8'h10, 32'h1122_0000, okay);
    axi_read(8'h00, cbbid, okay);

    // 4. interrupt set, delayed irq_out, W1C clear
    axi_write(8'h84, 32'h0000_0001, 4'hF, okay, 0);
    axi_read(8'h84, 32'h0000_0001, okay);
    irq_src[0] = 1'b1;
    tick();
    irq_src[0] = 1'b0;
    check("irq_lag", irq, 0);
    tick();
    check("irq_set", irq, 1);
    axi_read(8'h80, 32'h0000_0001, okay);
    axi_write(8'h80, 32'h0000_0001, 4'hF, okay, 0);
    check("irq_clear", irq, 0);
    axi_read(8'h80, 32'h0000_0000, okay);

    // 5. W1C landing in the same cycle as a new edge keeps the bit set
    tgt = b_seen + 1;
    exp_b.push_back(okay);
    drive_aw_w(8'h80, 32'h0000_0001, 4'hF);
    irq_src[0] = 1'b1;
    tick();
    wait_seen(1'b1, tgt, "b_w1c_race");
    axi_read(8'h80, 32'h0000_0001, okay);
    check("irq_race", irq, 1);
    irq_src[0] = 1'b0;
    axi_write(8'h80, 32'h0000_0001, 4'b0001, okay, -1);
    axi_read(8'h80, 32'h0000_0000, okay);

    // 6. concurrent read/write of the same word, then reset during RESP
    fork
      axi_read(8'h04, 32'h0000_0000, okay);
      axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, okay, 0);
    join
    axi_read(8'h04, 32'hDEAD_BEEF, okay);
    bready = 1'b0;
    drive_aw_w(8'h0C, 32'h7777_7777, 4'hF);
    for (int n = 0; n < 64 && !bvalid; n++) tick();
    check("resp_reached", bvalid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_bvalid", bvalid, 0);
    check("rst_async_control", control, 0);
    repeat (2) tick();
    rst_n  = 1'b1;
    bready = 1'b1;
    repeat (3) tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_bvalid", bvalid, 0);
    axi_read(8'h04, 32'h0000_0000, okay);
    check("queues_drained", {exp_r.size(), exp_b.size()}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
